lc3_mem_if: RTL and testbench
=============================

# lc3_mem_if

Memory interface stage for the LC-3 datapath: holds the MAR and MDR and runs the handshake between the control unit's `mio_en`/`r_w`/`R` protocol and an external request/acknowledge memory port. It sits on `data_bus` alongside the PC stage and directly consumes it. During fetch the PC stage drives `data_bus`, and this block latches the bus into MAR, reads memory and returns the instruction word through MDR. Wait states and non-responding memory are handled here, so the control unit only ever sees `R`.

## Interface
- `WAIT_LIMIT`, default 255: maximum cycles in REQ before the access is forced to complete with an error.
- `clk`  in  1  the single system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `ld_mar`  in  1  load MAR from `data_bus`.
- `ld_mdr`  in  1  load MDR. Source is memory data when `mio_en`=1, `data_bus` when `mio_en`=0.
- `mio_en`  in  1  memory access request from the control unit; held until `mem_r`.
- `r_w`  in  1  0 = read, 1 = write. Valid while `mio_en`.
- `gate_mdr`  in  1  drive MDR onto `data_bus`.
- `data_bus`  inout  16  shared datapath bus. High-Z unless `gate_mdr`.
- `mar`  out  16  current MAR.
- `mdr`  out  16  current MDR.
- `mem_r`  out  1  ready ("R") to the control unit.
- `mem_err`  out  1  one-cycle pulse, coincident with `mem_r`, on timeout.
- `mem_req`  out  1  external request. Held until acknowledged.
- `mem_we`  out  1  external write enable. Valid with `mem_req`.
- `mem_addr`  out  16  external address.
- `mem_wdata`  out  16  external write data.
- `mem_ack`  in  1  external acknowledge, one cycle.
- `mem_rdata`  in  16  external read data. Valid when `mem_ack`=1.

## Operation
- **Reset values:** `mar`, `mdr`, `mem_addr`, `mem_wdata` = x0000. `mem_req`, `mem_we`, `mem_r`, `mem_err` = 0. State is IDLE, wait counter is 0, read buffer is x0000.
- **MAR:** loads `data_bus` on any edge with `ld_mar`=1, in any state.
- **MDR:** loads `data_bus` when `ld_mdr`=1 and `mio_en`=0.
  - With `mio_en`=1, MDR loads only in DONE, only for reads, and only with `ld_mdr`=1; the source is the read buffer.
  - Otherwise MDR holds.
- **FSM states:** IDLE, REQ, DONE, DRAIN.
- **IDLE:**
  - If `mio_en`=1, go to REQ.
  - On that transition, snapshot `mem_addr`<=`mar`, `mem_wdata`<=`mdr`, `mem_we`<=`r_w`, and clear the counter.
- **REQ:**
  - `mem_req`=1. Snapshot values are frozen, so later `ld_mar`/`ld_mdr` does not disturb the bus.
  - If `mem_ack`=1, the read buffer takes `mem_rdata` (reads only). Then go to DONE if `mio_en`=1, otherwise to IDLE with the result discarded.
  - Else, if the counter equals `WAIT_LIMIT`-1, the read buffer takes x0000, `mem_err` is set for DONE, and the next state is DONE (or IDLE if `mio_en`=0).
  - Else the counter increments.
- **DONE:**
  - `mem_r`=1 for exactly one cycle. Go to DRAIN.
- **DRAIN:**
  - Wait for `mio_en`=0, then go to IDLE.
  - This prevents a back-to-back retrigger from the same request. DRAIN lasts one cycle when the control unit drops `mio_en` immediately.
- **Abort:** `mio_en` falling in REQ does not drop `mem_req`. The bus transaction completes, and `mem_r` is never asserted for it.
- **Bus contention:** `gate_mdr` together with another bus driver is a control-unit error and is not checked here. `ld_mar`=1 with `gate_mdr`=1 copies MDR into MAR.

## Timing
- All state and registers update on `posedge clk`. `rst` clears asynchronously, dropping `mem_req` immediately mid-access.
- **Zero-wait memory:**
  - `mio_en` first sampled at edge 0, so `mem_req`=1 after edge 0.
  - `mem_ack` sampled at edge 1, so `mem_r`=1 after edge 1.
  - MDR is updated at edge 2, so the control unit's `R` loop sees R one cycle after REQ.
- **Wait states:** each cycle of `mem_ack` latency adds one cycle.
- **Timeout:** `mem_r` and `mem_err` assert after `WAIT_LIMIT`+1 edges from the start.
- **Outputs:** `mem_r` and `mem_err` are registered-state decodes with no combinational path from inputs. `data_bus` drive is combinational from `gate_mdr`.
- **Counter width:** `$clog2(WAIT_LIMIT+1)`. The counter saturates and never wraps.

## Structure
- **Package `lc3_pkg`:** `WORD_W`=16, the memory-interface state enum (`MIF_IDLE`, `MIF_REQ`, `MIF_DONE`, `MIF_DRAIN`), and the default `WAIT_LIMIT`.
- **Sub-module `lc3_mem_fsm`:** contains the state register, the wait counter and the snapshot/read-buffer registers.
- **Top level:** MAR, MDR and the `data_bus` tristate stay in `lc3_mem_if`.

## Test plan
- **Reset:** assert `rst` mid-REQ (`mem_req`=1). Expect `mem_req`=0, `mar`=`mdr`=x0000 and state IDLE without a clock edge.
- **Fetch:**
  - `data_bus`=x0200 with `ld_mar`, then `mio_en`=1, `r_w`=0.
  - Memory acks after 3 cycles with x1234.
  - Expect `mem_addr`=x0200 and `mem_we`=0, `mem_r` high for one cycle, and `mdr`=x1234 after `ld_mdr`.
  - `gate_mdr` drives x1234 onto the bus.
- **Write:**
  - MAR=x3000, MDR=xBEEF (via bus), then `mio_en`=1, `r_w`=1.
  - Change MAR to x4000 during REQ.
  - Expect `mem_addr` to stay x3000 with `mem_wdata`=xBEEF and `mem_we`=1 until ack, then `mem_r`.
- **Timeout:** `WAIT_LIMIT`=4, never ack. Expect `mem_req` for 4 cycles, then `mem_r`=`mem_err`=1 for one cycle and `mdr`=x0000 after load.
- **Abort:** drop `mio_en` after 1 REQ cycle, ack 2 cycles later with x5555. Expect `mem_req` held until ack, `mem_r` never high and `mdr` unchanged.
- **Back-to-back:** hold `mio_en` through DONE. Expect no second request until `mio_en` falls, and a second access starting on the edge after `mio_en` reasserts.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 datapath memory interface.
package lc3_pkg;
   localparam int WORD_W         = 16;
   localparam int WAIT_LIMIT_DEF = 255;

   typedef enum logic [1:0] {
      MIF_IDLE,
      MIF_REQ,
      MIF_DONE,
      MIF_DRAIN
   } mif_state_t;
endpackage

// File: rtl/lc3_mem_fsm.sv
// Request/acknowledge handshake engine: state, wait counter, address/data snapshot
// and the read buffer that feeds MDR once the access completes.
module lc3_mem_fsm
   import lc3_pkg::*;
#(
   parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mio_en,
   input  logic              r_w,
   input  logic [WORD_W-1:0] mar,
   input  logic [WORD_W-1:0] mdr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_r,
   output logic              mem_err,
   output logic              rd_load,
   output logic [WORD_W-1:0] rbuf
);
   localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   mif_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              err, err_nxt;
   logic              snap;
   logic              rbuf_ld;
   logic [WORD_W-1:0] rbuf_val;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = err;
      snap      = 1'b0;
      rbuf_ld   = 1'b0;
      rbuf_val  = mem_rdata;
      case (state)
         MIF_IDLE: begin
            if (mio_en) begin
               state_nxt = MIF_REQ;
               cnt_nxt   = '0;
               snap      = 1'b1;
            end
         end
         MIF_REQ: begin
            // An abandoned access still runs to completion on the external port.
            if (mem_ack) begin
               rbuf_ld   = !mem_we;
               err_nxt   = 1'b0;
               state_nxt = mio_en ? MIF_DONE : MIF_IDLE;
            end else if (cnt == CNT_LAST) begin
               rbuf_ld   = 1'b1;
               rbuf_val  = '0;
               err_nxt   = 1'b1;
               state_nxt = mio_en ? MIF_DONE : MIF_IDLE;
            end else if (cnt != '1) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         MIF_DONE:  state_nxt = MIF_DRAIN;
         MIF_DRAIN: if (!mio_en) state_nxt = MIF_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= MIF_IDLE;
         cnt       <= '0;
         err       <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         rbuf      <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err   <= err_nxt;
         if (snap) begin
            mem_addr  <= mar;
            mem_wdata <= mdr;
            mem_we    <= r_w;
         end
         if (rbuf_ld) rbuf <= rbuf_val;
      end
   end

   assign mem_req = (state == MIF_REQ);
   assign mem_r   = (state == MIF_DONE);
   assign mem_err = mem_r & err;
   assign rd_load = mem_r & !mem_we;
endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface stage: MAR/MDR registers on the shared data bus plus the
// external memory handshake; the control unit only observes mem_r.
module lc3_mem_if
   import lc3_pkg::*;
#(
   parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_mar,
   input  logic              ld_mdr,
   input  logic              mio_en,
   input  logic              r_w,
   input  logic              gate_mdr,
   inout  logic [WORD_W-1:0] data_bus,
   output logic [WORD_W-1:0] mar,
   output logic [WORD_W-1:0] mdr,
   output logic              mem_r,
   output logic              mem_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata
);
   logic              rd_load;
   logic [WORD_W-1:0] rbuf;

   lc3_mem_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .mio_en    (mio_en),
      .r_w       (r_w),
      .mar       (mar),
      .mdr       (mdr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_r     (mem_r),
      .mem_err   (mem_err),
      .rd_load   (rd_load),
      .rbuf      (rbuf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mar <= '0;
         mdr <= '0;
      end else begin
         if (ld_mar) mar <= data_bus;
         if (ld_mdr) begin
            if (!mio_en)      mdr <= data_bus;
            else if (rd_load) mdr <= rbuf;
         end
      end
   end

   assign data_bus = gate_mdr ? mdr : 'z;
endmodule

// File: tb/tb_lc3_mem_if.sv
// Bench for lc3_mem_if: directed scenarios with literal expectations, then random
// control-unit/memory traffic checked every cycle against a transaction-level model.
module tb_lc3_mem_if;
   localparam int WL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
   logic        bus_oe;
   logic [15:0] bus_drv;
   wire  [15:0] data_bus;
   logic [15:0] mar, mdr, mem_addr, mem_wdata, mem_rdata;
   logic        mem_r, mem_err, mem_req, mem_we, mem_ack;

   int total = 0;
   int bad   = 0;

   assign data_bus = bus_oe ? bus_drv : 'z;

   always #5 clk = ~clk;

   lc3_mem_if #(.WAIT_LIMIT(WL)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_mar    (ld_mar),
      .ld_mdr    (ld_mdr),
      .mio_en    (mio_en),
      .r_w       (r_w),
      .gate_mdr  (gate_mdr),
      .data_bus  (data_bus),
      .mar       (mar),
      .mdr       (mdr),
      .mem_r     (mem_r),
      .mem_err   (mem_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   // Transaction-level view: one outstanding access, its wait time, a one-shot
   // ready pulse and a "must see mio_en drop" flag.
   typedef struct packed {
      logic [15:0] mar;
      logic [15:0] mdr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rbuf;
      logic        we;
      logic        busy;
      logic        ready;
      logic        err;
      logic        drain;
      logic [7:0]  waited;
   } mstate_t;

   mstate_t ms;

   function automatic mstate_t step(mstate_t s, logic lmar, logic lmdr, logic mio,
                                    logic rw, logic gate, logic [15:0] drv,
                                    logic ack, logic [15:0] rdata);
      mstate_t     n;
      logic [15:0] bv;
      n  = s;
      bv = gate ? s.mdr : drv;
      if (lmar) n.mar = bv;
      if (lmdr && !mio) n.mdr = bv;
      else if (lmdr && s.ready && !s.we) n.mdr = s.rbuf;
      if (s.ready) begin
         n.ready = 1'b0;
         n.err   = 1'b0;
         n.drain = 1'b1;
      end else if (s.drain) begin
         n.drain = mio;
      end else if (s.busy) begin
         if (ack || int'(s.waited) == WL - 1) begin
            n.busy  = 1'b0;
            n.ready = mio;
            n.err   = !ack;
            if (!ack) n.rbuf = 16'h0000;
            else if (!s.we) n.rbuf = rdata;
         end else begin
            n.waited = s.waited + 8'd1;
         end
      end else if (mio) begin
         n.busy   = 1'b1;
         n.waited = 8'd0;
         n.addr   = s.mar;
         n.wdata  = s.mdr;
         n.we     = rw;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) ms <= '0;
      else     ms <= step(ms, ld_mar, ld_mdr, mio_en, r_w, gate_mdr, bus_drv, mem_ack, mem_rdata);
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("mar", mar, ms.mar);
         chk("mdr", mdr, ms.mdr);
         chk("mem_addr", mem_addr, ms.addr);
         chk("mem_wdata", mem_wdata, ms.wdata);
         chk("mem_we", 16'(mem_we), 16'(ms.we));
         chk("mem_req", 16'(mem_req), 16'(ms.busy));
         chk("mem_r", 16'(mem_r), 16'(ms.ready));
         chk("mem_err", 16'(mem_err), 16'(ms.ready & ms.err));
         if (gate_mdr) chk("data_bus", data_bus, ms.mdr);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; gate_mdr = 0;
      bus_oe = 0; bus_drv = '0; mem_ack = 0; mem_rdata = '0;
   endtask

   int          rel, mw, lat;
   logic [15:0] saved_mdr;

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      rst = 1'b0;
      tick();

      // Fetch with three wait cycles
      bus_oe = 1; bus_drv = 16'h0200; ld_mar = 1;
      tick();
      chk("fetch mar", mar, 16'h0200);
      ld_mar = 0; bus_oe = 0; mio_en = 1; r_w = 0;
      tick();
      chk("fetch req", 16'(mem_req), 16'd1);
      chk("fetch addr", mem_addr, 16'h0200);
      chk("fetch we", 16'(mem_we), 16'd0);
      tick(); tick();
      mem_ack = 1; mem_rdata = 16'h1234;
      tick();
      chk("fetch r", 16'(mem_r), 16'd1);
      chk("fetch err", 16'(mem_err), 16'd0);
      mem_ack = 0; mem_rdata = 16'h0; ld_mdr = 1;
      tick();
      chk("fetch mdr", mdr, 16'h1234);
      chk("fetch r pulse", 16'(mem_r), 16'd0);
      ld_mdr = 0; mio_en = 0; gate_mdr = 1;
      tick();
      chk("fetch gate", data_bus, 16'h1234);
      gate_mdr = 0;

      // Write; MAR changes mid-request but the snapshot must not
      bus_oe = 1; bus_drv = 16'h3000; ld_mar = 1;
      tick();
      bus_drv = 16'hBEEF; ld_mar = 0; ld_mdr = 1;
      tick();
      chk("write mdr", mdr, 16'hBEEF);
      ld_mdr = 0; bus_oe = 0; mio_en = 1; r_w = 1;
      tick();
      bus_oe = 1; bus_drv = 16'h4000; ld_mar = 1;
      tick();
      chk("write mar moved", mar, 16'h4000);
      chk("write addr held", mem_addr, 16'h3000);
      chk("write wdata", mem_wdata, 16'hBEEF);
      chk("write we", 16'(mem_we), 16'd1);
      ld_mar = 0; bus_oe = 0; mem_ack = 1;
      tick();
      chk("write r", 16'(mem_r), 16'd1);
      mem_ack = 0; mio_en = 0;
      tick(); tick();

      // Timeout with WAIT_LIMIT=4: four request cycles, then ready+error
      mio_en = 1; r_w = 0;
      for (int i = 0; i < WL; i++) begin
         tick();
         chk("timeout req", 16'(mem_req), 16'd1);
         chk("timeout no r", 16'(mem_r), 16'd0);
      end
      tick();
      chk("timeout r", 16'(mem_r), 16'd1);
      chk("timeout err", 16'(mem_err), 16'd1);
      chk("timeout req drop", 16'(mem_req), 16'd0);
      ld_mdr = 1;
      tick();
      chk("timeout mdr", mdr, 16'h0000);
      chk("timeout err pulse", 16'(mem_err), 16'd0);
      ld_mdr = 0; mio_en = 0;
      tick(); tick();

      // Abort: control unit walks away, memory still finishes
      bus_oe = 1; bus_drv = 16'h7777; ld_mdr = 1;
      tick();
      saved_mdr = 16'h7777;
      ld_mdr = 0; bus_oe = 0; mio_en = 1; r_w = 0;
      tick();
      mio_en = 0;
      tick();
      chk("abort req held", 16'(mem_req), 16'd1);
      mem_ack = 1; mem_rdata = 16'h5555;
      tick();
      chk("abort req done", 16'(mem_req), 16'd0);
      chk("abort no r", 16'(mem_r), 16'd0);
      mem_ack = 0;
      tick();
      chk("abort no r later", 16'(mem_r), 16'd0);
      chk("abort mdr", mdr, saved_mdr);

      // Back-to-back: mio_en held through DONE must not retrigger
      mio_en = 1;
      tick();
      mem_ack = 1; mem_rdata = 16'hABCD;
      tick();
      chk("b2b r", 16'(mem_r), 16'd1);
      mem_ack = 0;
      tick(); tick(); tick();
      chk("b2b no retrigger", 16'(mem_req), 16'd0);
      mio_en = 0;
      tick();
      chk("b2b idle", 16'(mem_req), 16'd0);
      mio_en = 1;
      tick();
      chk("b2b second req", 16'(mem_req), 16'd1);

      // Asynchronous reset in the middle of a request
      #3 rst = 1'b1;
      #1;
      chk("rst req", 16'(mem_req), 16'd0);
      chk("rst mar", mar, 16'h0000);
      chk("rst mdr", mdr, 16'h0000);
      chk("rst r", 16'(mem_r), 16'd0);
      chk("rst addr", mem_addr, 16'h0000);
      idle_inputs();
      tick();
      rst = 1'b0;
      tick();

      // Random traffic
      rel = 0; mw = 0; lat = 0;
      for (int n = 0; n < 4000; n++) begin
         if (mio_en) begin
            if (rel != 0) begin
               rel--;
               if (rel == 0) mio_en = 0;
            end else if (mem_r) begin
               rel = $urandom_range(0, 2);
               if (rel == 0) mio_en = 0;
            end else if (mem_req && $urandom_range(0, 19) == 0) begin
               mio_en = 0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            mio_en = 1;
            r_w    = 1'($urandom_range(0, 1));
         end
         ld_mar   = ($urandom_range(0, 3) == 0);
         ld_mdr   = ($urandom_range(0, 2) == 0);
         gate_mdr = ($urandom_range(0, 5) == 0);
         bus_oe   = !gate_mdr;
         bus_drv  = 16'($urandom);
         if (mem_req) begin
            mem_ack   = (mw == lat);
            mem_rdata = 16'($urandom);
            mw++;
         end else begin
            mem_ack = 0;
            mw      = 0;
            lat     = $urandom_range(0, 5);
         end
         tick();
      end

      idle_inputs();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
